// File: rtl/usb_serial_pkg.sv
// Shared definitions for the USB serial FIFO bridge.
// Holds the Wishbone register map, STATUS/ISR/CTRL bit positions and the
// legal FIFO depth range. No ports; imported by the bridge top level.
package usb_serial_pkg;

  // Register map, decoded on wb_adr_i[2:0].
  typedef enum logic [2:0] {
    REG_DATA   = 3'd0,
    REG_STATUS = 3'd1,
    REG_CTRL   = 3'd2,
    REG_RXLVL  = 3'd3,
    REG_TXLVL  = 3'd4,
    REG_ISR    = 3'd5,
    REG_IER    = 3'd6,
    REG_RSVD   = 3'd7
  } reg_addr_e;

  // STATUS bit positions.
  localparam int ST_RX_NOT_EMPTY = 0;
  localparam int ST_TX_NOT_FULL  = 1;
  localparam int ST_TX_EMPTY     = 2;
  localparam int ST_RX_FULL      = 3;
  localparam int ST_LOOPBACK     = 6;
  localparam int ST_CONFIGURED   = 7;

  // ISR bit positions (0,1 live; 2..4 sticky).
  localparam int ISR_RX_NOT_EMPTY = 0;
  localparam int ISR_TX_EMPTY     = 1;
  localparam int ISR_TX_OVERFLOW  = 2;
  localparam int ISR_RX_UNDERFLOW = 3;
  localparam int ISR_CFG_CHANGE   = 4;

  // CTRL bit positions.
  localparam int CTRL_FLUSH_RX = 0;
  localparam int CTRL_FLUSH_TX = 1;
  localparam int CTRL_LOOPBACK = 2;

  // Legal FIFO depths (powers of two only).
  localparam int FIFO_DEPTH_MIN = 2;
  localparam int FIFO_DEPTH_MAX = 128;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO.
// Ports: clk/rst_n (async active-low), push+din, pop, flush (wins over
// push/pop), full, empty, level (0..DEPTH), head (oldest entry).
// Pointers carry one extra wrap bit so full/empty come from MSB comparison.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  input  logic             flush,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level   = wr_ptr - rd_ptr;
  assign head    = mem[rd_ptr[AW-1:0]];
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      // Collapse onto the write pointer: level reads 0 next cycle.
      rd_ptr <= wr_ptr;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/usb_serial_fifo_wb.sv
// Wishbone-to-USB byte stream bridge with RX/TX FIFOs, loopback and IRQ.
// Ports: clk, rst_n (async active-low); Wishbone slave wb_*; USB RX stream
// rx_data/rx_valid/rx_ready; USB TX stream tx_data/tx_valid/tx_ready;
// usb_configured (enumeration status); irq (registered, level high).
// Streams use valid/ready: a byte moves on a clock edge where both are high;
// valid never depends on ready.
// Every Wishbone side effect (pop, push, flush, W1C) happens on the edge
// that raises wb_ack_o, and wb_dat_o is captured on that same edge.
module usb_serial_fifo_wb
  import usb_serial_pkg::*;
#(
  parameter int RX_DEPTH = 16,
  parameter int TX_DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] wb_adr_i,
  input  logic [7:0] wb_dat_i,
  output logic [7:0] wb_dat_o,
  input  logic       wb_cyc_i,
  input  logic       wb_stb_i,
  input  logic       wb_we_i,
  output logic       wb_ack_o,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  input  logic       usb_configured,
  output logic       irq
);

  localparam int RX_LW = $clog2(RX_DEPTH) + 1;
  localparam int TX_LW = $clog2(TX_DEPTH) + 1;

  logic             rx_full, rx_empty, tx_full, tx_empty;
  logic [RX_LW-1:0] rx_level;
  logic [TX_LW-1:0] tx_level;
  logic [7:0]       rx_head, tx_head, rx_din;
  logic             rx_push, rx_pop, rx_flush, tx_push, tx_pop, tx_flush;
  logic             loopback, rx_ready_en, cfg_q;
  logic [4:2]       isr_sticky, isr_set, isr_clr;
  logic [7:0]       ier, status, isr, rd_data;
  logic             wb_req, wb_rd, wb_wr, lb_move, cfg_fall, cfg_rise;
  reg_addr_e        adr;
  logic             unused_adr_hi;

  assign unused_adr_hi = ^wb_adr_i[7:3];
  assign adr    = reg_addr_e'(wb_adr_i[2:0]);
  assign wb_req = wb_cyc_i && wb_stb_i && !wb_ack_o;
  assign wb_rd  = wb_req && !wb_we_i;
  assign wb_wr  = wb_req && wb_we_i;

  assign cfg_fall = cfg_q && !usb_configured;
  assign cfg_rise = !cfg_q && usb_configured;

  // rx_ready_en keeps rx_ready low through reset and the release cycle.
  assign rx_ready = rx_ready_en && !rx_full && !loopback;
  assign tx_valid = !tx_empty && !loopback;
  assign tx_data  = tx_empty ? 8'h00 : tx_head;

  // Loopback: TX head feeds RX directly, one byte per cycle.
  assign lb_move = loopback && !tx_empty && !rx_full;
  assign rx_din  = loopback ? tx_head : rx_data;
  assign rx_push = (rx_valid && rx_ready) || lb_move;
  assign rx_pop  = wb_rd && (adr == REG_DATA) && !rx_empty;
  assign tx_push = wb_wr && (adr == REG_DATA) && !tx_full;
  assign tx_pop  = (tx_valid && tx_ready) || lb_move;

  assign rx_flush = wb_wr && (adr == REG_CTRL) && wb_dat_i[CTRL_FLUSH_RX];
  assign tx_flush = (wb_wr && (adr == REG_CTRL) && wb_dat_i[CTRL_FLUSH_TX]) || cfg_fall;

  sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk(clk), .rst_n(rst_n), .push(rx_push), .din(rx_din), .pop(rx_pop),
    .flush(rx_flush), .full(rx_full), .empty(rx_empty), .level(rx_level),
    .head(rx_head)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk(clk), .rst_n(rst_n), .push(tx_push), .din(wb_dat_i), .pop(tx_pop),
    .flush(tx_flush), .full(tx_full), .empty(tx_empty), .level(tx_level),
    .head(tx_head)
  );

  always_comb begin
    status = 8'h00;
    status[ST_RX_NOT_EMPTY] = !rx_empty;
    status[ST_TX_NOT_FULL]  = !tx_full;
    status[ST_TX_EMPTY]     = tx_empty;
    status[ST_RX_FULL]      = rx_full;
    status[ST_LOOPBACK]     = loopback;
    status[ST_CONFIGURED]   = usb_configured;

    isr = {3'b000, isr_sticky, tx_empty, !rx_empty};

    isr_set = '0;
    isr_set[ISR_TX_OVERFLOW]  = wb_wr && (adr == REG_DATA) && tx_full;
    isr_set[ISR_RX_UNDERFLOW] = wb_rd && (adr == REG_DATA) && rx_empty;
    isr_set[ISR_CFG_CHANGE]   = cfg_fall || cfg_rise;
    isr_clr = (wb_wr && (adr == REG_ISR)) ? wb_dat_i[4:2] : 3'b000;

    rd_data = 8'h00;
    case (adr)
      REG_DATA:   rd_data = rx_empty ? 8'h00 : rx_head;
      REG_STATUS: rd_data = status;
      REG_RXLVL:  rd_data = 8'(rx_level);
      REG_TXLVL:  rd_data = 8'(tx_level);
      REG_ISR:    rd_data = isr;
      REG_IER:    rd_data = ier;
      default:    rd_data = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_ack_o    <= 1'b0;
      wb_dat_o    <= 8'h00;
      rx_ready_en <= 1'b0;
      cfg_q       <= 1'b0;
      loopback    <= 1'b0;
      isr_sticky  <= '0;
      ier         <= 8'h00;
      irq         <= 1'b0;
    end else begin
      wb_ack_o    <= wb_req;
      if (wb_req) wb_dat_o <= wb_rd ? rd_data : 8'h00;
      rx_ready_en <= 1'b1;
      cfg_q       <= usb_configured;
      if (wb_wr && (adr == REG_CTRL)) loopback <= wb_dat_i[CTRL_LOOPBACK];
      if (wb_wr && (adr == REG_IER))  ier <= wb_dat_i;
      // Set is OR-ed after the clear so a coincident event is not lost.
      isr_sticky  <= (isr_sticky & ~isr_clr) | isr_set;
      irq         <= |(isr[4:0] & ier[4:0]);
    end
  end

endmodule

// File: tb/tb_usb_serial_fifo_wb.sv
// Self-checking bench for usb_serial_fifo_wb (default depths).
module tb_usb_serial_fifo_wb;

  localparam int RXD = 16;
  localparam int TXD = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] wb_adr_i, wb_dat_i, wb_dat_o;
  logic       wb_cyc_i, wb_stb_i, wb_we_i, wb_ack_o;
  logic [7:0] rx_data, tx_data;
  logic       rx_valid, rx_ready, tx_valid, tx_ready;
  logic       usb_configured, irq;

  usb_serial_fifo_wb #(.RX_DEPTH(RXD), .TX_DEPTH(TXD)) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
    .wb_ack_o(wb_ack_o),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .usb_configured(usb_configured), .irq(irq)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  logic [8:0] exp_q[$];      // {is_read, expected read data} per Wishbone access
  logic [7:0] m_rx[$];
  logic [7:0] m_tx[$];
  logic [4:2] m_sticky;
  logic [7:0] m_ier;
  logic       m_lb;
  int         checks = 0;
  int         failures = 0;
  bit         mon_en = 0;
  int         tx_mode = 0;   // 0: tx_ready low, 1: random, 2: high

  function automatic logic [7:0] m_isr();
    return {3'b000, m_sticky, m_tx.size() == 0, m_rx.size() != 0};
  endfunction

  function automatic logic [7:0] m_status();
    return {usb_configured, m_lb, 2'b00, m_rx.size() == RXD,
            m_tx.size() == 0, m_tx.size() != TXD, m_rx.size() != 0};
  endfunction

  task automatic model_reset();
    m_rx.delete();
    m_tx.delete();
    m_sticky = '0;
    m_ier    = 8'h00;
    m_lb     = 1'b0;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%02h expected=%02h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Expected values are taken from the model before the sampling edge;
  // model updates are applied just after that edge.
  task automatic wb_read(input logic [2:0] a);
    logic [7:0] e;
    logic [4:0] hi;
    bit pop, unf;
    pop = 0; unf = 0; e = 8'h00;
    case (a)
      3'd0: if (m_rx.size() != 0) begin e = m_rx[0]; pop = 1; end else unf = 1;
      3'd1: e = m_status();
      3'd3: e = 8'(m_rx.size());
      3'd4: e = 8'(m_tx.size());
      3'd5: e = m_isr();
      3'd6: e = m_ier;
      default: e = 8'h00;
    endcase
    exp_q.push_back({1'b1, e});
    hi = 5'($urandom);
    wb_adr_i = {hi, a}; wb_we_i = 1'b0; wb_dat_i = 8'($urandom);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    @(posedge clk); #1;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    if (pop) void'(m_rx.pop_front());
    if (unf) m_sticky[3] = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic wb_write(input logic [2:0] a, input logic [7:0] d);
    bit was_full;
    was_full = (m_tx.size() == TXD);
    exp_q.push_back({1'b0, 8'h00});
    wb_adr_i = {5'b00000, a}; wb_we_i = 1'b1; wb_dat_i = d;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    @(posedge clk); #1;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    case (a)
      3'd0: if (was_full) m_sticky[2] = 1'b1; else m_tx.push_back(d);
      3'd2: begin
        if (d[0]) m_rx.delete();
        if (d[1]) m_tx.delete();
        m_lb = d[2];
      end
      3'd5: m_sticky = m_sticky & ~d[4:2];
      3'd6: m_ier = d;
      default: ;
    endcase
    @(posedge clk); #1;
  endtask

  task automatic rx_send(input logic [7:0] b);
    bit rdy;
    rdy = (m_rx.size() < RXD) && !m_lb;
    rx_data = b; rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    if (rdy) m_rx.push_back(b);
  endtask

  task automatic cfg_set(input logic v);
    logic old;
    old = usb_configured;
    usb_configured = v;
    @(posedge clk); #1;
    if (old != v) m_sticky[4] = 1'b1;
    if (old && !v) m_tx.delete();
  endtask

  // Loopback drains TX into RX as room allows.
  task automatic lb_settle();
    while (m_tx.size() != 0 && m_rx.size() < RXD) m_rx.push_back(m_tx.pop_front());
  endtask

  task automatic check_irq();
    repeat (2) @(posedge clk);
    #1;
    chk("irq", {7'b0, irq}, {7'b0, |(m_isr() & m_ier[4:0])});
  endtask

  task automatic wait_tx_drain();
    for (int i = 0; i < 200 && m_tx.size() != 0; i++) @(posedge clk);
    #1;
    chk("tx_drain_bound", 8'(m_tx.size()), 8'h00);
  endtask

  // ---------------- tx_ready driver ----------------
  initial begin
    tx_ready = 1'b0;
    forever begin
      @(posedge clk); #2;
      case (tx_mode)
        0: tx_ready = 1'b0;
        1: tx_ready = 1'($urandom_range(0, 1));
        default: tx_ready = 1'b1;
      endcase
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [8:0] e;
    if (mon_en) begin
      chk("tx_valid", {7'b0, tx_valid}, {7'b0, (m_tx.size() != 0) && !m_lb});
      if (m_tx.size() != 0 && !m_lb) begin
        chk("tx_data", tx_data, m_tx[0]);
        if (tx_ready) void'(m_tx.pop_front());
      end
      chk("rx_ready", {7'b0, rx_ready}, {7'b0, (m_rx.size() < RXD) && !m_lb});
    end
    if (wb_ack_o) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_ack actual=1 expected=0 t=%0t", $time);
      end else begin
        e = exp_q.pop_front();
        if (e[8]) chk("wb_read", wb_dat_o, e[7:0]);
        else checks++;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0; wb_adr_i = 8'h00; wb_dat_i = 8'h00; wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0; wb_we_i = 1'b0; rx_data = 8'h00; rx_valid = 1'b0;
    usb_configured = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", {7'b0, wb_ack_o}, 8'h00);
    chk("rst_dat_o", wb_dat_o, 8'h00);
    chk("rst_rx_ready", {7'b0, rx_ready}, 8'h00);
    chk("rst_tx_valid", {7'b0, tx_valid}, 8'h00);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_irq", {7'b0, irq}, 8'h00);
    rst_n = 1'b1;
    #1;
    chk("rx_ready_after_release", {7'b0, rx_ready}, 8'h00);
    @(posedge clk); #1;
    mon_en = 1'b1;

    // Enumeration: rising edge flags cfg_change.
    cfg_set(1'b1);
    wb_read(3'd5);
    wb_write(3'd5, 8'h10);
    wb_read(3'd5);
    wb_read(3'd1);
    wb_read(3'd7);
    wb_read(3'd2);

    // TX path, first-word fall-through.
    wb_write(3'd0, 8'h41);
    wb_write(3'd0, 8'h42);
    tx_mode = 2;
    wait_tx_drain();
    tx_mode = 0;
    @(posedge clk); #1;
    wb_read(3'd4);
    wb_read(3'd1);

    // TX overflow with IER bit2.
    wb_write(3'd6, 8'h04);
    wb_read(3'd6);
    for (int i = 0; i < TXD + 1; i++) wb_write(3'd0, 8'($urandom));
    wb_read(3'd4);
    wb_read(3'd5);
    check_irq();
    wb_write(3'd2, 8'h02);
    wb_read(3'd4);
    wb_write(3'd5, 8'h04);
    wb_write(3'd6, 8'h00);
    check_irq();

    // RX fill to full; extra byte is refused.
    for (int i = 0; i < RXD + 1; i++) rx_send(8'(8'h10 + i));
    wb_read(3'd3);
    wb_read(3'd1);
    wb_read(3'd0);
    wb_read(3'd0);
    wb_read(3'd3);
    wb_write(3'd2, 8'h01);
    wb_read(3'd3);

    // RX underflow.
    wb_read(3'd0);
    wb_read(3'd5);
    wb_write(3'd5, 8'h08);
    wb_read(3'd5);

    // Loopback.
    wb_write(3'd2, 8'h04);
    wb_write(3'd0, 8'h55);
    lb_settle();
    wb_read(3'd3);
    wb_read(3'd1);
    wb_read(3'd0);
    wb_write(3'd2, 8'h00);

    // Randomized traffic with a random USB consumer.
    tx_mode = 1;
    for (int i = 0; i < 250; i++) begin
      case ($urandom_range(0, 6))
        0, 1: if (m_rx.size() < RXD - 2) rx_send(8'($urandom)); else wb_read(3'd0);
        2: if (m_tx.size() < TXD - 2) wb_write(3'd0, 8'($urandom)); else wb_read(3'd4);
        3: wb_read(3'd0);
        4: wb_read(3'd3);
        5: wb_read(3'd4);
        default: wb_read(3'($urandom_range(1, 5)));
      endcase
    end
    tx_mode = 2;
    wait_tx_drain();
    tx_mode = 0;
    @(posedge clk); #1;
    wb_write(3'd2, 8'h01);
    wb_write(3'd5, 8'h1C);

    // Unconfigure flushes TX.
    for (int i = 0; i < 3; i++) wb_write(3'd0, 8'(8'hA0 + i));
    wb_read(3'd4);
    cfg_set(1'b0);
    wb_read(3'd4);
    wb_read(3'd5);
    wb_write(3'd6, 8'h10);
    check_irq();

    // Reset in the middle of an access.
    wb_write(3'd0, 8'hC3);
    rx_send(8'hAA);
    wb_adr_i = 8'h01; wb_we_i = 1'b0; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    #2;
    mon_en = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_ack", {7'b0, wb_ack_o}, 8'h00);
    chk("midrst_dat_o", wb_dat_o, 8'h00);
    chk("midrst_tx_valid", {7'b0, tx_valid}, 8'h00);
    chk("midrst_tx_data", tx_data, 8'h00);
    chk("midrst_rx_ready", {7'b0, rx_ready}, 8'h00);
    chk("midrst_irq", {7'b0, irq}, 8'h00);
    @(posedge clk); #1;
    chk("midrst_ack_held", {7'b0, wb_ack_o}, 8'h00);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    model_reset();
    rst_n = 1'b1;
    @(posedge clk); #1;
    mon_en = 1'b1;
    wb_read(3'd1);
    wb_read(3'd3);
    wb_read(3'd5);

    repeat (3) @(posedge clk);
    #1;
    chk("acks_outstanding", 8'(exp_q.size()), 8'h00);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
